pipe_scroller: RTL and testbench

//  Downstream consumer of the pipe-pattern generator. Each scroll tick it samples
//  the generator's 8-bit column pattern, shifts a COLS-wide column buffer left,
//  and feeds the display driver. Flags bird/pipe collision and keeps the score.

---
 rtl/pipe_scroller.sv | 113 +++++++++++
 tb/tb_pipe_scroller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Scrolling column buffer fed by the pipe-pattern generator; flags bird/pipe collision and keeps score.
// Optional `PIPE_SCROLL_SPEEDUP_EN: scroll period halves every 8 points, down to TICK_DIV/8.
module pipe_scroller #(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned TICK_DIV = 1024,
  parameter int unsigned GAP      = 3,
  parameter int unsigned BIRD_COL = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ROWS-1:0]         pipe_pattern,
  output logic                    pattern_take,
  input  logic [ROWS-1:0]         bird_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [ROWS-1:0]         rd_data,
  output logic                    scroll_tick,
  output logic                    collision,
  output logic [7:0]              score
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  logic [1:0]      r_state;
  logic [ROWS-1:0] r_col [COLS];
  logic [TW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_pattern_take;
  logic            r_scroll_tick;
  logic            r_collision;
  logic [7:0]      r_score;

  logic [TW-1:0]   w_last;
  logic            w_tick;
  logic            w_hit;
  logic            w_run;
  logic            w_shift;

`ifdef PIPE_SCROLL_SPEEDUP_EN
  logic [1:0] w_lvl;
  always_comb begin
    w_lvl  = (r_score[7:3] > 5'd3) ? 2'd3 : r_score[4:3];
    w_last = TW'((TICK_DIV >> w_lvl) - 1);
    // >= catches a count already past a freshly shortened period
    w_tick = (r_cnt >= w_last);
  end
`else
  always_comb begin
    w_last = TW'(TICK_DIV - 1);
    w_tick = (r_cnt == w_last);
  end
`endif

  assign w_run   = (r_state == RUN);
  assign w_hit   = |(r_col[BIRD_COL] & bird_row);
  assign w_shift = w_run && w_tick && !w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_gap          <= '0;
      r_pattern_take <= 1'b0;
      r_scroll_tick  <= 1'b0;
      r_collision    <= 1'b0;
      r_score        <= '0;
      for (int unsigned i = 0; i < COLS; i++) r_col[i] <= '0;
    end else begin
      r_scroll_tick  <= w_shift;
      r_pattern_take <= w_shift && (r_gap == '0);

      case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN: begin
          if (w_hit) begin
            r_state     <= DEAD;
            r_collision <= 1'b1;
          end else if (!enable) begin
            r_state <= IDLE;
          end
        end
        DEAD:    r_state <= DEAD;
        default: r_state <= IDLE;
      endcase

      if (w_run) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;

      if (w_shift) begin
        for (int unsigned i = 0; i < COLS - 1; i++) r_col[i] <= r_col[i+1];
        r_col[COLS-1] <= (r_gap == '0) ? pipe_pattern : '0;
        r_gap         <= (r_gap == GW'(GAP)) ? '0 : r_gap + 1'b1;
        if ((r_col[BIRD_COL] != '0) && (r_score != 8'hFF)) r_score <= r_score + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_col) < COLS) rd_data = r_col[rd_col];
  end

  assign pattern_take = r_pattern_take;
  assign scroll_tick  = r_scroll_tick;
  assign collision    = r_collision;
  assign score        = r_score;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller (TICK_DIV=8, GAP=3, COLS=16, BIRD_COL=2); honours PIPE_SCROLL_SPEEDUP_EN.
module tb_pipe_scroller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] pipe_pattern;
  logic       pattern_take;
  logic [7:0] bird_row;
  logic [3:0] rd_col;
  logic [7:0] rd_data;
  logic       scroll_tick;
  logic       collision;
  logic [7:0] score;

  int vectors = 0;
  int miscompares = 0;

  pipe_scroller #(.COLS(16), .ROWS(8), .TICK_DIV(8), .GAP(3), .BIRD_COL(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pipe_pattern(pipe_pattern),
    .pattern_take(pattern_take), .bird_row(bird_row), .rd_col(rd_col), .rd_data(rd_data),
    .scroll_tick(scroll_tick), .collision(collision), .score(score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [3:0] c);
    rd_col = c;
    #1;
  endtask

  // Steps until scroll_tick is seen; n is the number of edges taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!scroll_tick && n < 64);
    chk("tick_timeout", int'(scroll_tick), 1);
  endtask

  function automatic int exp_period(input int s);
`ifdef PIPE_SCROLL_SPEEDUP_EN
    int lvl;
    lvl = s / 8;
    if (lvl > 3) lvl = 3;
    return 8 >> lvl;
`else
    return 8 + 0 * s;
`endif
  endfunction

  // Pipes every 4th tick from tick 1; each is scored 14 ticks after being loaded.
  function automatic int exp_score(input int t);
    int s;
    if (t < 15) return 0;
    s = (t - 15) / 4 + 1;
    return (s > 255) ? 255 : s;
  endfunction

  initial begin
    int n;
    int seen;

    // 1: reset state, first tick latency, gap insertion
    reset = 1'b1; enable = 1'b1; pipe_pattern = 8'hC3; bird_row = 8'h10; rd_col = 4'd15;
    step(); step();
    chk("rst_scroll_tick", int'(scroll_tick), 0);
    chk("rst_pattern_take", int'(pattern_take), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_col15", int'(rd_data), 0);
    reset = 1'b0;
    step();
    wait_tick(n);
    chk("first_tick_latency", n, 8);
    chk("first_take", int'(pattern_take), 1);
    chk("first_col15", int'(rd_data), 'hC3);
    for (int t = 2; t <= 4; t++) begin
      wait_tick(n);
      chk("gap_spacing", n, 8);
      chk("gap_take", int'(pattern_take), 0);
      chk("gap_col15", int'(rd_data), 0);
    end
    pipe_pattern = 8'h81;
    wait_tick(n);
    chk("tick5_take", int'(pattern_take), 1);
    chk("tick5_col15", int'(rd_data), 'h81);
    set_rd(4'd11);
    chk("tick5_col11", int'(rd_data), 'hC3);
    pipe_pattern = 8'h00;

    // 2: pause at tick_cnt=5 for 20+ cycles, resume
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 21; i++) begin
      step();
      if (scroll_tick) seen++;
    end
    chk("pause_no_tick", seen, 0);
    enable = 1'b1;
    step();
    chk("resume_c1", int'(scroll_tick), 0);
    step();
    chk("resume_c2", int'(scroll_tick), 0);
    step();
    chk("resume_c3_tick", int'(scroll_tick), 1);

    // 3: bird row 4 clears C3 and 81, both scored as they leave column 2
    for (int t = 7; t <= 14; t++) begin
      wait_tick(n);
      chk("run_spacing", n, 8);
    end
    set_rd(4'd2);
    chk("t14_col2", int'(rd_data), 'hC3);
    chk("t14_score", int'(score), 0);
    wait_tick(n);
    chk("t15_score", int'(score), 1);
    chk("t15_no_collision", int'(collision), 0);
    for (int t = 16; t <= 18; t++) wait_tick(n);
    chk("t18_col2", int'(rd_data), 'h81);
    wait_tick(n);
    chk("t19_score", int'(score), 2);

    // 4: bird row 0 hits C3 at column 2
    reset = 1'b1;
    step();
    chk("midgame_reset_score", int'(score), 0);
    chk("midgame_reset_col2", int'(rd_data), 0);
    reset = 1'b0; bird_row = 8'h01; pipe_pattern = 8'hC3;
    step();
    for (int t = 1; t <= 14; t++) wait_tick(n);
    chk("hit_col2", int'(rd_data), 'hC3);
    chk("hit_pre_collision", int'(collision), 0);
    step();
    chk("hit_collision", int'(collision), 1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (scroll_tick) seen++;
    end
    chk("dead_no_tick", seen, 0);
    chk("dead_score", int'(score), 0);
    chk("dead_col2_frozen", int'(rd_data), 'hC3);
    chk("dead_collision_sticky", int'(collision), 1);
    reset = 1'b1;
    step();
    chk("dead_reset_collision", int'(collision), 0);
    chk("dead_reset_col2", int'(rd_data), 0);
    chk("dead_reset_scroll", int'(scroll_tick), 0);

    // 5/6: long run with no bird (never hits), score saturation, tick spacing vs score
    reset = 1'b0; bird_row = 8'h00; pipe_pattern = 8'h81;
    step();
    for (int t = 1; t <= 1043; t++) begin
      wait_tick(n);
      chk("spacing", n, exp_period(exp_score(t - 1)));
      chk("score", int'(score), exp_score(t));
    end
    chk("sat_score", int'(score), 255);
    chk("no_hit_bird0", int'(collision), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
